count_controller: RTL and testbench

//   Sequences the 4-bit display counter feeding the 7-segment decoder: run/pause/step/clear
//   FSM, two selectable advance rates, up/down direction, programmable wrap limit.

---
 rtl/count_controller.sv | 134 +++++++++++++
 tb/tb_count_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_controller.sv
// Display-counter sequencer: run/pause/step/clear control of a 4-bit count with two
// advance rates, up/down direction and a programmable wrap limit.
module count_controller #(
    parameter int unsigned g_Delay_Fast = 2500000,
    parameter int unsigned g_Delay_Slow = 25000000,
    parameter int unsigned g_Max        = 15
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Run_Toggle,
    input  logic       i_Step,
    input  logic       i_Clear,
    input  logic       i_Dir,
    input  logic       i_Speed,
    output logic [3:0] o_Nibble,
    output logic       o_Running,
    output logic       o_Tick,
    output logic       o_Wrap
);

    // state | meaning
    // IDLE  | stopped, count forced to 0
    // RUN   | auto-advance once per selected period
    // PAUSE | stopped, count held (also entered after a manual step)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0]  MAX_NIB   = 4'(g_Max);
    localparam logic [31:0] LAST_FAST = 32'(g_Delay_Fast) - 32'd1;
    localparam logic [31:0] LAST_SLOW = 32'(g_Delay_Slow) - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] delay_q, delay_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        running_q, running_d;
    logic        tick_q, tick_d;
    logic        wrap_q, wrap_d;

    logic [31:0] last_count;
    logic        advance;

    // Rate is re-evaluated every cycle so a speed change takes effect mid-period.
    assign last_count = i_Speed ? LAST_FAST : LAST_SLOW;

    always_comb begin
        state_d  = state_q;
        delay_d  = delay_q;
        advance  = 1'b0;

        if (i_Clear) begin
            state_d = ST_IDLE;
            delay_d = '0;
        end else if (i_Run_Toggle) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
            delay_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (delay_q >= last_count) begin
                        advance = 1'b1;
                        delay_d = '0;
                    end else begin
                        delay_d = delay_q + 32'd1;
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    if (i_Step) begin
                        advance = 1'b1;
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    delay_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        nibble_d  = nibble_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        running_d = (state_d == ST_RUN);

        if (i_Clear) begin
            nibble_d = '0;
        end else if (advance) begin
            tick_d = 1'b1;
            if (i_Dir) begin
                if (nibble_q >= MAX_NIB) begin
                    nibble_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    nibble_d = nibble_q + 4'd1;
                end
            end else begin
                if (nibble_q == 4'd0) begin
                    nibble_d = MAX_NIB;
                    wrap_d   = 1'b1;
                end else begin
                    nibble_d = nibble_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            delay_q   <= '0;
            nibble_q  <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            nibble_q  <= nibble_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign o_Nibble  = nibble_q;
    assign o_Running = running_q;
    assign o_Tick    = tick_q;
    assign o_Wrap    = wrap_q;

endmodule

// File: tb/tb_count_controller.sv
// Bench for count_controller: directed scenarios plus random button traffic, checked
// cycle by cycle against a queue of outputs predicted by a simple counting model.
module tb_count_controller;

    localparam int FAST = 4;
    localparam int SLOW = 10;
    localparam int MAX  = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       tog, stp, clr, dir, spd;
    logic [3:0] nib;
    logic       run_o, tick, wrap;

    always #5 clk = ~clk;

    count_controller #(
        .g_Delay_Fast(FAST),
        .g_Delay_Slow(SLOW),
        .g_Max       (MAX)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Run_Toggle(tog),
        .i_Step      (stp),
        .i_Clear     (clr),
        .i_Dir       (dir),
        .i_Speed     (spd),
        .o_Nibble    (nib),
        .o_Running   (run_o),
        .o_Tick      (tick),
        .o_Wrap      (wrap)
    );

    typedef struct {
        int         cyc;
        logic [3:0] nib;
        logic       run;
        logic       tick;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;

    // Reference model: mode 0 stopped-at-zero, 1 running, 2 stopped-holding.
    int m_mode, m_count, m_since;
    bit cur_dir, cur_spd;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    exp_t mon_e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != edge_cnt) begin
                errors++;
                $display("FAIL sb_stale: entry for cycle %0d still queued at cycle %0d", mon_e.cyc, edge_cnt);
            end else if ({nib, run_o, tick, wrap} !== {mon_e.nib, mon_e.run, mon_e.tick, mon_e.wrap}) begin
                errors++;
                $display("FAIL outputs@cyc%0d: got nib=%0d run=%0b tick=%0b wrap=%0b, expected nib=%0d run=%0b tick=%0b wrap=%0b",
                         edge_cnt, nib, run_o, tick, wrap, mon_e.nib, mon_e.run, mon_e.tick, mon_e.wrap);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_count = 0;
        m_since = 0;
    endtask

    // Outcome of one clock edge given the buttons held during the preceding cycle.
    task automatic model_step(input bit c, input bit t, input bit s, input bit d, input bit sp,
                              output bit tk, output bit wr);
        int  period;
        bit  adv;
        period = sp ? FAST : SLOW;
        adv = 0;
        tk  = 0;
        wr  = 0;
        if (c) begin
            m_mode  = 0;
            m_count = 0;
            m_since = 0;
        end else if (t) begin
            m_mode  = (m_mode == 1) ? 2 : 1;
            m_since = 0;
        end else if (m_mode == 1) begin
            if (m_since + 1 >= period) begin
                adv     = 1;
                m_since = 0;
            end else begin
                m_since = m_since + 1;
            end
        end else if (s) begin
            adv    = 1;
            m_mode = 2;
        end
        if (adv) begin
            tk = 1;
            if (d) begin
                wr      = (m_count == MAX);
                m_count = (m_count + 1) % (MAX + 1);
            end else begin
                wr      = (m_count == 0);
                m_count = (m_count + MAX) % (MAX + 1);
            end
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive(input bit c, input bit t, input bit s);
        exp_t e;
        bit   tk, wr;
        clr = c;
        tog = t;
        stp = s;
        dir = cur_dir;
        spd = cur_spd;
        model_step(c, t, s, cur_dir, cur_spd, tk, wr);
        e.cyc  = edge_cnt + 1;
        e.nib  = 4'(m_count);
        e.run  = (m_mode == 1);
        e.tick = tk;
        e.wrap = wr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        clr = 0;
        tog = 0;
        stp = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    // Assert reset after the mid-cycle sample, verify it acts without a clock, release after the edge.
    task automatic mid_reset();
        exp_t e;
        clr = 0;
        tog = 0;
        stp = 0;
        #6;
        rst = 1;
        #1;
        chk("async_reset_outputs", {nib, run_o, tick, wrap}, 0);
        model_reset();
        e.cyc  = edge_cnt + 1;
        e.nib  = 0;
        e.run  = 0;
        e.tick = 0;
        e.wrap = 0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst = 1;
        clr = 0; tog = 0; stp = 0; dir = 1; spd = 1;
        cur_dir = 1;
        cur_spd = 1;
        model_reset();
        #2;
        chk("reset_outputs", {nib, run_o, tick, wrap}, 0);
        @(posedge clk);
        #1;
        rst = 0;

        // Fast up-count: ten advances end on the 9->0 wrap.
        drive(0, 1, 0);
        chk("run_entry_running", run_o, 1);
        idle(40);
        chk("run10_nibble", nib, 0);
        chk("run10_wrap", wrap, 1);
        chk("run10_tick", tick, 1);

        // Pause at 0, then a down step wraps to the limit.
        drive(0, 1, 0);
        chk("pause_running", run_o, 0);
        cur_dir = 0;
        drive(0, 0, 1);
        chk("step_down_nibble", nib, MAX);
        chk("step_down_wrap", wrap, 1);
        chk("step_down_tick", tick, 1);
        chk("step_down_paused", run_o, 0);

        // Steps during RUN must not add advances.
        drive(0, 1, 0);
        idle(2);
        drive(0, 0, 1);
        idle(1);
        drive(0, 0, 1);
        idle(8);

        // Slow period interrupted by a switch to fast after six cycles.
        cur_spd = 0;
        drive(1, 0, 0);
        drive(0, 1, 0);
        idle(6);
        cur_spd = 1;
        drive(0, 0, 0);
        chk("speed_switch_tick", tick, 1);
        idle(8);

        // Clear beats Run_Toggle while running at 5.
        cur_dir = 1;
        drive(1, 0, 0);
        drive(0, 1, 0);
        idle(20);
        chk("run_to_5", nib, 5);
        drive(1, 1, 0);
        chk("clear_tog_nibble", nib, 0);
        chk("clear_tog_running", run_o, 0);

        // Pause holds its value; resume restarts a full period; reset mid-period.
        drive(0, 1, 0);
        idle(9);
        drive(0, 1, 0);
        idle(7);
        drive(0, 1, 0);
        idle(2);
        mid_reset();
        idle(3);

        // Random button traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if ($urandom_range(0, 99) < 5) cur_dir = ~cur_dir;
            if ($urandom_range(0, 99) < 4) cur_spd = ~cur_spd;
            if (r < 3)
                mid_reset();
            else if (r < 23)
                drive(1, $urandom_range(0, 1), $urandom_range(0, 1));
            else if (r < 80)
                drive(0, 1, $urandom_range(0, 1));
            else if (r < 160)
                drive(0, 0, 1);
            else
                drive(0, 0, 0);
        end

        idle(2);
        #5;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
